// File: rtl/adc_pipe_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : adc_pipe_output_buffer
// Purpose  : Output buffer downstream of the pipelined ADC encoder. Registers
//            each conversion result, optionally block-averages it, and queues
//            the results in a small FIFO drained over a valid/ready handshake.
// Macro    : ADC_OUTBUF_AVG_EN - when defined, builds the averaging decimator
//            (one result per 2**AVG_LOG2 valid samples). When undefined, every
//            valid sample is pushed unchanged and AVG_LOG2 has no effect.
// Ports    : clk_i          - single clock, rising edge
//            reset_n_i      - asynchronous active-low reset
//            sample_i       - ADC code from the encoder
//            sample_valid_i - sample_i holds a new conversion this cycle
//            flush_i        - synchronous clear of FIFO, averager, overflow
//            data_o         - FIFO head (0 when empty)
//            valid_o        - data_o holds a valid entry
//            ready_i        - consumer accepts data_o this cycle
//            level_o        - number of stored entries, 0..FIFO_DEPTH
//            overflow_o     - sticky: at least one result was dropped
// Revision : 1.0 - initial release
// ============================================================================
module adc_pipe_output_buffer #(
  parameter  int DATA_WIDTH = 3,
  parameter  int FIFO_DEPTH = 8,
  parameter  int AVG_LOG2   = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LVL_W-1:0]      level_o,
  output logic                  overflow_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Input stage
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  svld_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sample_q <= '0;
      svld_q   <= 1'b0;
    end else begin
      sample_q <= sample_i;
      // A sample captured in a flush cycle belongs to the discarded stream.
      svld_q   <= sample_valid_i && !flush_i;
    end
  end

  // --------------------------------------------------------------------------
  // Result generation
  // --------------------------------------------------------------------------
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;

`ifdef ADC_OUTBUF_AVG_EN
  localparam int ACC_W = DATA_WIDTH + AVG_LOG2;

  // Sum of 2**AVG_LOG2 codes of DATA_WIDTH bits always fits in ACC_W bits.
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] cnt;

  assign acc_sum   = acc + ACC_W'(sample_q);
  assign push      = svld_q && (&cnt);
  assign push_data = acc_sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (svld_q) begin
      // Counter wraps naturally on the last sample of a block.
      cnt <= cnt + 1'b1;
      acc <= (&cnt) ? '0 : acc_sum;
    end
  end
`else
  assign push      = svld_q;
  assign push_data = sample_q;
`endif

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [LVL_W-1:0]      wr_ptr;
  logic [LVL_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  wr_en;

  assign level = wr_ptr - rd_ptr;
  // Full: same index bits, differing wrap bit.
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && ready_i;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) begin
      mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Head is masked while empty so that reset and flush present a zero code
  // without having to clear the storage array.
  assign data_o  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
  assign valid_o = !empty;
  assign level_o = level;

endmodule
`default_nettype wire
